// File: rtl/be8_pkg.sv
// Shared constants and types for the be8 bus controller: default port addresses,
// the access FSM state encoding and the status-register bit layout.
package be8_pkg;

    localparam logic [7:0] BE8_IO_ADDR_DEF   = 8'hFE;
    localparam logic [7:0] BE8_STAT_ADDR_DEF = 8'hFD;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_DONE = 1'b1
    } be8_state_e;

    // Status byte: {overflow, 2'b00, fill count}
    localparam int STAT_OVF_BIT = 7;
    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 5;

endpackage

// File: rtl/be8_io_fifo.sv
// Output-port FIFO for the be8 bus controller. A pop while empty is ignored and a
// push while full is accepted only when a pop frees a slot in the same cycle.
module be8_io_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_data,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/be8_bus_ctrl.sv
// be8 bus controller: wait-state access FSM, RAM pass-through, output-port FIFO and readback.
// Define BE8_BUS_STATUS_EN to map the read-only status register at STAT_ADDR.
module be8_bus_ctrl
    import be8_pkg::*;
#(
    parameter int         WAIT_STATES = 1,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] IO_ADDR     = BE8_IO_ADDR_DEF,
    parameter logic [7:0] STAT_ADDR   = BE8_STAT_ADDR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic [7:0] io_data,
    output logic       io_valid,
    input  logic       io_ack,
    output logic       io_ovf,
    output be8_state_e o_dbg_state
);
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] WS        = 4'(WAIT_STATES);
    localparam be8_state_e RST_STATE = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
`ifdef BE8_BUS_STATUS_EN
    localparam logic STAT_EN = 1'b1;
`else
    localparam logic STAT_EN = 1'b0;
`endif

    be8_state_e    r_state;
    be8_state_e    w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          r_ovf;
    logic [7:0]    r_io_last;
    logic          w_done;
    logic          w_wr;
    logic          w_is_io;
    logic          w_is_stat;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_status;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RST_STATE;
            r_cnt   <= WS;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // WAIT lasts WAIT_STATES cycles, DONE exactly one; with zero wait states DONE never exits.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == ST_WAIT) begin
            if (r_cnt <= 4'd1) begin
                w_state_nxt = ST_DONE;
                w_cnt_nxt   = 4'd0;
            end else begin
                w_cnt_nxt = r_cnt - 4'd1;
            end
        end else if (WS != 4'd0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WS;
        end
    end

    // Gating with rst keeps a write that is in flight when reset arrives from reaching RAM or the FIFO.
    assign w_done    = (r_state == ST_DONE) && rst;
    assign w_wr      = w_done && cpu_rw;
    assign w_is_io   = (cpu_addr == IO_ADDR);
    assign w_is_stat = STAT_EN && (cpu_addr == STAT_ADDR);
    assign w_push    = w_wr && w_is_io;

    assign cpu_ready   = w_done;
    assign mem_addr    = cpu_addr;
    assign mem_wdata   = cpu_wdata;
    assign mem_we      = w_wr && !w_is_io && !w_is_stat;
    assign o_dbg_state = r_state;

    be8_io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_pop   (io_ack),
        .i_data  (cpu_wdata),
        .o_data  (io_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign io_valid = !w_empty;
    assign io_ovf   = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf     <= 1'b0;
            r_io_last <= 8'h00;
        end else if (w_push) begin
            if (!w_full || io_ack) r_io_last <= cpu_wdata;
            else                   r_ovf     <= 1'b1;
        end
    end

    always_comb begin
        w_status = '0;
        w_status[STAT_OVF_BIT] = r_ovf;
        w_status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(w_count);
    end

    always_comb begin
        cpu_rdata = mem_rdata;
        if (w_is_io)        cpu_rdata = r_io_last;
        else if (w_is_stat) cpu_rdata = w_status;
    end

endmodule

// File: tb/tb_be8_bus_ctrl.sv
// Bench for be8_bus_ctrl: directed scenarios plus random traffic checked against a
// cycle-count / queue reference model. Two instances: WAIT_STATES=2 and WAIT_STATES=0.
module tb_be8_bus_ctrl;
    import be8_pkg::*;

    localparam int         WS    = 2;
    localparam int         DEPTH = 4;
    localparam logic [7:0] IO_A  = 8'hFE;
    localparam logic [7:0] ST_A  = 8'hFD;
`ifdef BE8_BUS_STATUS_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] cpu_addr;
    logic       cpu_rw;
    logic [7:0] cpu_wdata;
    logic       io_ack;

    logic [7:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata, io_data;
    logic       cpu_ready, mem_we, io_valid, io_ovf;
    be8_state_e dbg_state;
    logic [7:0] cpu_rdata0, mem_addr0, mem_wdata0, mem_rdata0, io_data0;
    logic       cpu_ready0, mem_we0, io_valid0, io_ovf0;
    be8_state_e dbg_state0;

    bit [7:0]   ram [256];
    bit [7:0]   ram0 [256];
    bit [7:0]   ref_ram [256];
    logic [7:0] exp_q [$];
    logic       exp_ovf;
    logic [7:0] exp_last;
    int         cyc;
    int         n_chk;
    int         n_err;

    be8_bus_ctrl #(.WAIT_STATES(WS), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .io_data(io_data), .io_valid(io_valid),
        .io_ack(io_ack), .io_ovf(io_ovf), .o_dbg_state(dbg_state)
    );

    be8_bus_ctrl #(.WAIT_STATES(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata0), .cpu_ready(cpu_ready0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_we(mem_we0), .mem_rdata(mem_rdata0), .io_data(io_data0), .io_valid(io_valid0),
        .io_ack(io_ack), .io_ovf(io_ovf0), .o_dbg_state(dbg_state0)
    );

    // Clock / RAM behaviour
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata  = ram[mem_addr];
    assign mem_rdata0 = ram0[mem_addr0];

    always @(posedge clk) begin
        if (mem_we)  ram[mem_addr]   <= mem_wdata;
        if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, check combinational outputs against the model, advance the model.
    task automatic drive_cycle(input logic r, input logic [7:0] a, input logic rw,
                               input logic [7:0] wd, input logic ack);
        logic       exp_rdy;
        logic       exp_we;
        logic       is_stat;
        logic [7:0] exp_rd;
        @(negedge clk);
        rst = r; cpu_addr = a; cpu_rw = rw; cpu_wdata = wd; io_ack = ack;
        #1;
        exp_rdy = r && (cyc % (WS + 1) == WS);
        is_stat = STAT_ON && (a == ST_A);
        exp_we  = exp_rdy && rw && (a != IO_A) && !is_stat;
        if (a == IO_A)  exp_rd = exp_last;
        else if (is_stat) exp_rd = {exp_ovf, 2'b00, 5'(exp_q.size())};
        else            exp_rd = ref_ram[a];
        check("cpu_ready", 16'(cpu_ready), 16'(exp_rdy));
        check("mem_we", 16'(mem_we), 16'(exp_we));
        check("cpu_rdata", 16'(cpu_rdata), 16'(exp_rd));
        check("mem_addr", 16'(mem_addr), 16'(a));
        check("mem_wdata", 16'(mem_wdata), 16'(wd));
        check("io_valid", 16'(io_valid), 16'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("io_data", 16'(io_data), 16'(exp_q[0]));
        check("io_ovf", 16'(io_ovf), 16'(exp_ovf));
        check("ws0_ready", 16'(cpu_ready0), 16'(r));
        check("ws0_mem_we", 16'(mem_we0), 16'(r && rw && (a != IO_A) && !is_stat));
        if (!r) begin
            cyc = 0;
            exp_q.delete();
            exp_ovf  = 1'b0;
            exp_last = 8'h00;
        end else begin
            if (ack && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_rdy && rw) begin
                if (a == IO_A) begin
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(wd);
                        exp_last = wd;
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end else if (!is_stat) begin
                    ref_ram[a] = wd;
                end
            end
            cyc++;
        end
        @(posedge clk);
        #1;
    endtask

    // Hold an access until its completion cycle; io_ack is raised only on that cycle.
    task automatic access(input logic [7:0] a, input logic rw, input logic [7:0] wd, input logic ack_done);
        logic fin;
        int   guard;
        fin   = 1'b0;
        guard = 0;
        while (!fin && guard <= WS) begin
            fin = (cyc % (WS + 1) == WS);
            drive_cycle(1'b1, a, rw, wd, fin ? ack_done : 1'b0);
            guard++;
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) drive_cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] a;
        int         sel;
        n_chk = 0; n_err = 0; cyc = 0;
        exp_ovf = 1'b0; exp_last = 8'h00;
        rst = 1'b0; cpu_addr = 8'h00; cpu_rw = 1'b0; cpu_wdata = 8'h00; io_ack = 1'b0;

        // Reset state and IO readback after reset
        do_reset(2);
        check("rst_state", 16'(dbg_state), 16'(ST_WAIT));
        check("rst_state_ws0", 16'(dbg_state0), 16'(ST_DONE));
        check("rst_io_valid", 16'(io_valid), 16'h0);
        drive_cycle(1'b1, IO_A, 1'b0, 8'h00, 1'b0);

        // Steady read of 0x10 holding 0x5A: ready pattern 0,0,1
        access(8'h10, 1'b1, 8'h5A, 1'b0);
        do_reset(1);
        repeat (9) drive_cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);

        // Continuous write of 0x33 to 0x20
        do_reset(1);
        repeat (3) drive_cycle(1'b1, 8'h20, 1'b1, 8'h33, 1'b0);
        check("ws0_ram20", 16'(ram0[8'h20]), 16'h0033);
        check("ram20", 16'(ram[8'h20]), 16'h0033);

        // Five pushes into a depth-4 FIFO with no consumer
        do_reset(1);
        for (int v = 1; v <= 5; v++) access(IO_A, 1'b1, 8'(v), 1'b0);
        check("ovf_set", 16'(io_ovf), 16'h1);
        check("ovf_head", 16'(io_data), 16'h0001);
        check("ovf_ramFE", 16'(ram[IO_A]), 16'h0000);
        access(IO_A, 1'b0, 8'h00, 1'b0);
        check("readback", 16'(cpu_rdata), 16'h0004);

        // Push and pop together while full
        do_reset(1);
        for (int v = 1; v <= 4; v++) access(IO_A, 1'b1, 8'(v), 1'b0);
        access(IO_A, 1'b1, 8'hAA, 1'b1);
        check("pp_head", 16'(io_data), 16'h0002);
        check("pp_ovf", 16'(io_ovf), 16'h0);
        repeat (4) drive_cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        check("pp_drained", 16'(io_valid), 16'h0);

        // Push and pop together while empty: ack is ignored, byte becomes head
        access(IO_A, 1'b1, 8'h5C, 1'b1);
        check("pe_head", 16'(io_data), 16'h005C);

`ifdef BE8_BUS_STATUS_EN
        do_reset(1);
        for (int v = 1; v <= 3; v++) access(IO_A, 1'b1, 8'(v), 1'b0);
        access(ST_A, 1'b0, 8'h00, 1'b0);
        check("stat_3", 16'(cpu_rdata), 16'h0003);
        for (int v = 4; v <= 5; v++) access(IO_A, 1'b1, 8'(v), 1'b0);
        access(ST_A, 1'b0, 8'h00, 1'b0);
        check("stat_ovf", 16'(cpu_rdata), 16'h0084);
`endif

        // Reset during the wait phase of a write
        do_reset(1);
        drive_cycle(1'b1, 8'h30, 1'b1, 8'h77, 1'b0);
        drive_cycle(1'b0, 8'h30, 1'b1, 8'h77, 1'b0);
        check("rw_ram30", 16'(ram[8'h30]), 16'h0000);
        check("rw_state", 16'(dbg_state), 16'(ST_WAIT));
        check("rw_ready", 16'(cpu_ready), 16'h0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1:    a = IO_A;
                2:       a = ST_A;
                3:       a = 8'h10;
                default: a = 8'($urandom_range(0, 255));
            endcase
            drive_cycle(($urandom_range(0, 99) != 0), a, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/be8_bus_ctrl.md
BE8_BUS_CTRL -- requirements
Module: be8_bus_ctrl

Interface
REQ-001 Parameter WAIT_STATES, default 1, number of cycles cpu_ready stays low before each access completes (0..15).
REQ-002 Parameter FIFO_DEPTH, default 4, entries in the output-port FIFO (power of two, 2..16).
REQ-003 Parameter IO_ADDR, default 8'hFE, address of the write-only output port.
REQ-004 Parameter STAT_ADDR, default 8'hFD, address of the read-only status register.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 cpu_addr  in  8  CPU address.
REQ-008 cpu_rw  in  1  1 = CPU write, 0 = CPU read.
REQ-009 cpu_wdata  in  8  CPU write data.
REQ-010 cpu_rdata  out  8  read data returned to the CPU.
REQ-011 cpu_ready  out  1  access-complete strobe to the CPU.
REQ-012 mem_addr  out  8  RAM address; mem_wdata out 8, RAM write data; mem_we out 1, RAM write enable; mem_rdata in 8, RAM read data.
REQ-013 io_data  out  8  FIFO head; io_valid out 1, head valid; io_ack in 1, consumer accepts head.
REQ-014 io_ovf  out  1  sticky overflow flag.

Function
REQ-015 The block SHALL treat every bus cycle as an access and run a two-state FSM: WAIT (down-counter nonzero, cpu_ready=0) -> DONE (cpu_ready=1 for exactly one cycle) -> WAIT with counter reloaded to WAIT_STATES.
REQ-016 With WAIT_STATES=0 the FSM SHALL stay in DONE and hold cpu_ready=1 continuously.
REQ-017 mem_addr SHALL equal cpu_addr and mem_wdata SHALL equal cpu_wdata combinationally.
REQ-018 mem_we SHALL be 1 only in DONE with cpu_rw=1 and cpu_addr not IO_ADDR or STAT_ADDR (STAT_ADDR exclusion only with the Configuration macro defined).
REQ-019 A DONE write to IO_ADDR SHALL push cpu_wdata into the FIFO and never write RAM.
REQ-020 Push when full with no simultaneous pop SHALL drop the data and set io_ovf; io_ovf SHALL stay 1 until reset.
REQ-021 Simultaneous push and pop when full SHALL both succeed with no overflow; simultaneous push and pop when empty SHALL leave the pushed byte as the new head.
REQ-022 io_valid SHALL equal FIFO not-empty; a pop occurs on a cycle with io_valid=1 and io_ack=1; io_ack while empty SHALL be ignored.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the fill count SHALL be width clog2(FIFO_DEPTH)+1.
REQ-024 cpu_rdata SHALL be mem_rdata for all reads except IO_ADDR, which returns the last byte accepted into the FIFO (8'h00 after reset).

Reset
REQ-025 With rst=0 at a rising edge: cpu_ready=0, FSM=WAIT with counter=WAIT_STATES (DONE when WAIT_STATES=0), FIFO empty, io_valid=0, io_ovf=0, IO readback register=8'h00.
REQ-026 mem_we SHALL be 0 while rst=0; a write in progress when reset asserts SHALL be discarded.

Configuration
REQ-027 Macro BE8_BUS_STATUS_EN defined: reads of STAT_ADDR SHALL return {io_ovf, 2'b00, fill count zero-extended to 5 bits} and RAM writes to STAT_ADDR SHALL be suppressed.
REQ-028 BE8_BUS_STATUS_EN undefined: STAT_ADDR SHALL be ordinary RAM for reads and writes.

Structure
REQ-029 Package be8_pkg SHALL hold the default IO_ADDR/STAT_ADDR constants, the FSM state enumeration and status-bit position constants.
REQ-030 The FIFO SHALL be a separate sub-module be8_io_fifo (push, pop, data, count, full, empty); the FSM and decode stay in be8_bus_ctrl.

Verification
REQ-031 WAIT_STATES=2, steady read of 8'h10 with RAM[10]=8'h5A -> cpu_ready pattern 0,0,1 repeating; cpu_rdata=8'h5A on each ready cycle.
REQ-032 WAIT_STATES=0, write 8'h33 to 8'h20 -> mem_we=1 every cycle; RAM[20]=8'h33.
REQ-033 Writes 8'h01..8'h05 to 8'hFE with io_ack=0, depth 4 -> FIFO holds 01..04; io_ovf=1; RAM[FE] unchanged; read of 8'hFE returns 8'h04.
REQ-034 Full FIFO, io_ack=1 on the same cycle as a push of 8'hAA -> io_data 01 popped; AA stored; io_ovf stays 0.
REQ-035 BE8_BUS_STATUS_EN, three bytes queued -> read of 8'hFD returns 8'h03; after overflow returns 8'h84 (full, depth 4).
REQ-036 rst=0 asserted during a WAIT cycle of a write -> no mem_we pulse; all outputs at reset values on the next cycle.
